// File: rtl/udp_tx_pkt_buf_pkg.sv
// Shared definitions for the UDP transmit packet buffer and its neighbours.
// State encoding of the buffer FSM and the end-of-line byte used by the UART bridge.
package udp_tx_pkt_buf_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        SEND    = 2'd2
    } buf_state_t;

    localparam logic [7:0] LF_BYTE = 8'h0A;

endpackage

// File: rtl/udp_tx_pkt_buf_ram.sv
// Simple dual-port DEPTH x 8 byte RAM with registered read port.
// Written while collecting, read while sending; maps onto a block RAM.
module udp_pkt_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_tx_pkt_buf.sv
// Single-buffer packet store between the UART-to-UDP bridge and the UDP TX engine.
// Collects bytes, freezes on LF or full, announces the length and serves bytes on request.
module udp_tx_pkt_buf
    import udp_tx_pkt_buf_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rec_en,
    input  logic [7:0]       rec_data,
    input  logic             tx_start_en,
    output logic             udp_tx_start,
    output logic [LEN_W-1:0] udp_tx_byte_num,
    input  logic             udp_tx_req,
    output logic [7:0]       udp_tx_data,
    input  logic             udp_tx_done,
    output logic             busy,
    output logic [15:0]      drop_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    buf_state_t         state;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_ptr;
    logic               use_ram;
    logic               ram_we;
    logic               ram_re;
    logic               rd_in_range;
    logic [7:0]         ram_rdata;

    assign rd_in_range = (LEN_W'(rd_ptr) < udp_tx_byte_num);
    assign ram_we      = (state == COLLECT) && rec_en;
    assign ram_re      = (state == SEND) && udp_tx_req && !udp_tx_done && rd_in_range;

    udp_pkt_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_cnt[ADDR_W-1:0]),
        .wdata (rec_data),
        .re    (ram_re),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // The RAM output register cannot be reset, so a registered select forces
    // 0x00 after reset and after an over-read instead of stale RAM contents.
    assign udp_tx_data = use_ram ? ram_rdata : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= COLLECT;
            wr_cnt          <= '0;
            rd_ptr          <= '0;
            use_ram         <= 1'b0;
            udp_tx_start    <= 1'b0;
            udp_tx_byte_num <= '0;
            busy            <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            udp_tx_start <= 1'b0;

            if (rec_en && (state != COLLECT) && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                COLLECT: begin
                    if (rec_en) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        if (tx_start_en || (wr_cnt == CNT_W'(DEPTH - 1))) begin
                            udp_tx_byte_num <= LEN_W'(wr_cnt) + LEN_W'(1);
                            udp_tx_start    <= 1'b1;
                            busy            <= 1'b1;
                            state           <= START;
                        end
                    end else if (tx_start_en && (wr_cnt != '0)) begin
                        udp_tx_byte_num <= LEN_W'(wr_cnt);
                        udp_tx_start    <= 1'b1;
                        busy            <= 1'b1;
                        state           <= START;
                    end
                end

                START: begin
                    rd_ptr <= '0;
                    state  <= SEND;
                end

                SEND: begin
                    if (udp_tx_done) begin
                        wr_cnt <= '0;
                        rd_ptr <= '0;
                        busy   <= 1'b0;
                        state  <= COLLECT;
                    end else if (udp_tx_req) begin
                        use_ram <= rd_in_range;
                        if (rd_in_range)
                            rd_ptr <= rd_ptr + CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// Scoreboard bench for udp_tx_pkt_buf (DEPTH=16): stimulus queues expected starts/bytes,
// a monitor pops and compares them whenever the DUT pulses start or answers a request.
module tb_udp_tx_pkt_buf;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rec_en;
    logic [7:0]       rec_data;
    logic             tx_start_en;
    logic             udp_tx_start;
    logic [LEN_W-1:0] udp_tx_byte_num;
    logic             udp_tx_req;
    logic [7:0]       udp_tx_data;
    logic             udp_tx_done;
    logic             busy;
    logic [15:0]      drop_cnt;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [15:0] exp_len_q  [$];
    logic [7:0]  exp_data_q [$];
    logic [7:0]  pkt        [$];
    logic        req_seen   = 1'b0;

    udp_tx_pkt_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rec_en          (rec_en),
        .rec_data        (rec_data),
        .tx_start_en     (tx_start_en),
        .udp_tx_start    (udp_tx_start),
        .udp_tx_byte_num (udp_tx_byte_num),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_done     (udp_tx_done),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: requests sampled at the active edge, answers checked on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            req_seen = udp_tx_req;
            @(negedge clk);
            if (udp_tx_start) begin
                if (exp_len_q.size() == 0)
                    chk("unexpected_start", 32'd1, 32'd0);
                else
                    chk("byte_num", 32'(udp_tx_byte_num), 32'(exp_len_q.pop_front()));
            end
            if (req_seen) begin
                if (exp_data_q.size() == 0)
                    chk("unexpected_data", 32'd1, 32'd0);
                else
                    chk("tx_data", 32'(udp_tx_data), 32'(exp_data_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_str(input string s);
        pkt.delete();
        for (int i = 0; i < s.len(); i++)
            pkt.push_back(s[i]);
    endtask

    task automatic send_pkt(input bit with_lf);
        exp_len_q.push_back(16'(pkt.size()));
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            rec_en      = 1'b1;
            rec_data    = pkt[i];
            tx_start_en = with_lf && (i == pkt.size() - 1);
        end
        @(negedge clk);
        rec_en      = 1'b0;
        tx_start_en = 1'b0;
    endtask

    // Returns on the first falling edge in SEND (one cycle after the start pulse).
    task automatic wait_start();
        int unsigned n = 0;
        while (!udp_tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(udp_tx_start), 32'd1);
        @(negedge clk);
    endtask

    task automatic read_pkt(input int unsigned extra);
        for (int i = 0; i < pkt.size() + int'(extra); i++) begin
            @(negedge clk);
            exp_data_q.push_back(i < pkt.size() ? pkt[i] : 8'h00);
            udp_tx_req = 1'b1;
        end
        @(negedge clk);
        udp_tx_req = 1'b0;
    endtask

    task automatic finish_pkt();
        @(negedge clk);
        udp_tx_done = 1'b1;
        @(negedge clk);
        udp_tx_done = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rec_en      = 1'b0;
        rec_data    = 8'h00;
        tx_start_en = 1'b0;
        udp_tx_req  = 1'b0;
        udp_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_start", 32'(udp_tx_start), 32'd0);
        chk("rst_byte_num", 32'(udp_tx_byte_num), 32'd0);
        chk("rst_data", 32'(udp_tx_data), 32'd0);
        rst_n = 1'b1;

        // "AB\n" terminated packet
        load_str("AB\n");
        send_pkt(1'b1);
        chk("busy_in_start", 32'(busy), 32'd1);
        wait_start();
        read_pkt(0);
        finish_pkt();

        // Lone end-of-line with empty buffer: no start (monitor flags any)
        @(negedge clk);
        tx_start_en = 1'b1;
        @(negedge clk);
        tx_start_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("empty_lf_busy", 32'(busy), 32'd0);

        // Auto-flush on full buffer
        pkt.delete();
        for (int i = 0; i < DEPTH; i++)
            pkt.push_back(8'(i));
        send_pkt(1'b0);
        wait_start();
        read_pkt(0);
        finish_pkt();

        // Drops while sending, including one with tx_start_en and one on the done cycle
        load_str("X\n");
        send_pkt(1'b1);
        wait_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rec_en      = 1'b1;
            rec_data    = 8'h30 + 8'(i);
            tx_start_en = (i == 2);
        end
        @(negedge clk);
        rec_en      = 1'b0;
        tx_start_en = 1'b0;
        chk("drop_cnt_5", 32'(drop_cnt), 32'd5);
        read_pkt(0);
        @(negedge clk);
        udp_tx_done = 1'b1;
        rec_en      = 1'b1;
        rec_data    = 8'h77;
        @(negedge clk);
        udp_tx_done = 1'b0;
        rec_en      = 1'b0;
        chk("drop_on_done", 32'(drop_cnt), 32'd6);
        chk("busy_after_done2", 32'(busy), 32'd0);

        load_str("Z\n");
        send_pkt(1'b1);
        wait_start();
        read_pkt(0);
        finish_pkt();

        // Over-read returns zeros
        load_str("A\n");
        send_pkt(1'b1);
        wait_start();
        read_pkt(2);
        finish_pkt();

        // Reset in the middle of SEND
        load_str("R\n");
        send_pkt(1'b1);
        wait_start();
        @(negedge clk);
        rec_en   = 1'b1;
        rec_data = 8'h55;
        @(negedge clk);
        rec_en = 1'b0;
        exp_data_q.push_back(8'h52);
        udp_tx_req = 1'b1;
        @(negedge clk);
        udp_tx_req = 1'b0;
        chk("drop_before_rst", 32'(drop_cnt), 32'd7);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_data", 32'(udp_tx_data), 32'd0);

        load_str("Q\n");
        send_pkt(1'b1);
        wait_start();
        read_pkt(0);
        finish_pkt();

        repeat (4) @(negedge clk);
        chk("len_queue_empty", 32'(exp_len_q.size()), 32'd0);
        chk("data_queue_empty", 32'(exp_data_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
